bus_region_decoder: RTL and testbench

Parametrised, registered CPU address decoder for the M107-family main bus. It replaces the fixed casex decode with a runtime-programmable region table, a bank register with per-region bank substitution, and a per-region wait-state counter that produces a ready handshake. It sits between the V33 bus interface and the ROM/RAM/VRAM/peripheral selects.

---
 rtl/m107_pkg.sv | 49 ++++
 rtl/bus_region_decoder_match.sv | 33 +++
 rtl/bus_region_decoder.sv | 156 +++++++++++++++
 tb/tb_bus_region_decoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m107_pkg.sv
// Shared types and constants for the M107 main-bus region decoder:
// table entry struct, decoder state enum and the stock M107 address map.
package m107_pkg;

    // Table entries are stored at a fixed maximum width so the package
    // can stay unparameterised; narrower buses zero-extend into them.
    localparam int ADDR_MAX = 32;
    localparam int WAIT_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dec_state_t;

    typedef struct packed {
        logic [ADDR_MAX-1:0] base;
        logic [ADDR_MAX-1:0] mask;
        logic [WAIT_MAX-1:0] wait_cnt;
        logic                bank_en;
        logic                valid;
    } region_cfg_t;

    // Stock M107 map, listed in priority order (index 0 first).
    localparam int M107_NUM_DEFAULT = 7;

    localparam region_cfg_t M107_ROM = '{
        base: 32'h000C0000, mask: 32'h000F0000,
        wait_cnt: 8'd1, bank_en: 1'b0, valid: 1'b1};
    localparam region_cfg_t M107_PF_VRAM = '{
        base: 32'h000D0000, mask: 32'h000F0000,
        wait_cnt: 8'd2, bank_en: 1'b0, valid: 1'b1};
    localparam region_cfg_t M107_RAM = '{
        base: 32'h000E0000, mask: 32'h000F0000,
        wait_cnt: 8'd0, bank_en: 1'b0, valid: 1'b1};
    localparam region_cfg_t M107_RESET_VEC = '{
        base: 32'h000FFFF0, mask: 32'h000FFFF0,
        wait_cnt: 8'd1, bank_en: 1'b0, valid: 1'b1};
    localparam region_cfg_t M107_BUFFER = '{
        base: 32'h000F8000, mask: 32'h000F8000,
        wait_cnt: 8'd1, bank_en: 1'b0, valid: 1'b1};
    localparam region_cfg_t M107_EEPROM = '{
        base: 32'h000F0000, mask: 32'h000F8000,
        wait_cnt: 8'd3, bank_en: 1'b0, valid: 1'b1};
    localparam region_cfg_t M107_BANK_ROM = '{
        base: 32'h000A0000, mask: 32'h000E0000,
        wait_cnt: 8'd1, bank_en: 1'b1, valid: 1'b1};

endpackage

// File: rtl/bus_region_decoder_match.sv
// Combinational priority matcher: lowest valid entry whose care bits
// equal the address wins. Ports: per-entry base/mask/valid, addr in; idx, hit, onehot out.
module region_match
    import m107_pkg::*;
#(
    parameter int NUM_REGIONS = 8,
    parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
    input  logic [ADDR_MAX-1:0]    bases  [NUM_REGIONS],
    input  logic [ADDR_MAX-1:0]    masks  [NUM_REGIONS],
    input  logic                   valids [NUM_REGIONS],
    input  logic [ADDR_MAX-1:0]    addr,
    output logic [IDX_W-1:0]       idx,
    output logic                   hit,
    output logic [NUM_REGIONS-1:0] onehot
);

    // Scan from the top down so the lowest matching index is the last
    // assignment and therefore wins.
    always_comb begin
        idx    = '0;
        hit    = 1'b0;
        onehot = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (valids[i] && (((addr ^ bases[i]) & masks[i]) == '0)) begin
                idx    = IDX_W'(i);
                hit    = 1'b1;
                onehot = NUM_REGIONS'(1) << i;
            end
        end
    end

endmodule

// File: rtl/bus_region_decoder.sv
// Registered M107 bus decoder: programmable region table, bank substitution,
// per-region wait states and ready handshake. Ports: cfg_* table write,
// bank_* bank register write, mreq/A request in; sel, miss, out_addr, ready out.
module bus_region_decoder
    import m107_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int NUM_REGIONS = 8,
    parameter int BANK_W      = 4,
    parameter int WAIT_W      = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]              cfg_base,
    input  logic [ADDR_W-1:0]              cfg_mask,
    input  logic [WAIT_W-1:0]              cfg_wait,
    input  logic                           cfg_bank_en,
    input  logic                           cfg_valid,
    input  logic                           bank_we,
    input  logic [BANK_W-1:0]              bank_din,
    input  logic [BANK_W-1:0]              bank_mask,
    input  logic                           mreq,
    input  logic [ADDR_W-1:0]              A,
    output logic [NUM_REGIONS-1:0]         sel,
    output logic                           miss,
    output logic [ADDR_W-1:0]              out_addr,
    output logic                           ready
);

    localparam int IDX_W = $clog2(NUM_REGIONS);

    region_cfg_t         regions [NUM_REGIONS];
    logic [BANK_W-1:0]   bank_q;
    logic [BANK_W-1:0]   bank_mask_q;
    dec_state_t          state;
    logic [WAIT_MAX-1:0] cnt;

    logic [ADDR_MAX-1:0]    bases  [NUM_REGIONS];
    logic [ADDR_MAX-1:0]    masks  [NUM_REGIONS];
    logic                   valids [NUM_REGIONS];
    logic [ADDR_MAX-1:0]    a_ext;
    logic [IDX_W-1:0]       win_idx;
    logic                   hit;
    logic [NUM_REGIONS-1:0] hit_sel;
    logic [WAIT_MAX-1:0]    win_wait;
    logic                   win_bank;
    logic [BANK_W-1:0]      a_top;
    logic [BANK_W-1:0]      sub_top;
    logic [ADDR_W-1:0]      xlat_addr;

    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            bases[i]  = regions[i].base;
            masks[i]  = regions[i].mask;
            valids[i] = regions[i].valid;
        end
    end

    assign a_ext = ADDR_MAX'(A);

    region_match #(
        .NUM_REGIONS (NUM_REGIONS)
    ) u_match (
        .bases  (bases),
        .masks  (masks),
        .valids (valids),
        .addr   (a_ext),
        .idx    (win_idx),
        .hit    (hit),
        .onehot (hit_sel)
    );

    // A miss behaves as a zero-wait, non-banked access.
    always_comb begin
        win_wait  = hit ? regions[win_idx].wait_cnt : '0;
        win_bank  = hit & regions[win_idx].bank_en;
        a_top     = A[ADDR_W-1 -: BANK_W];
        sub_top   = (bank_q & bank_mask_q) | (a_top & ~bank_mask_q);
        xlat_addr = A;
        if (win_bank) begin
            xlat_addr[ADDR_W-1 -: BANK_W] = sub_top;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                regions[i] <= '0;
            end
            bank_q      <= '0;
            bank_mask_q <= '0;
        end else begin
            if (cfg_we) begin
                regions[cfg_idx] <= '{
                    base:     ADDR_MAX'(cfg_base),
                    mask:     ADDR_MAX'(cfg_mask),
                    wait_cnt: WAIT_MAX'(cfg_wait),
                    bank_en:  cfg_bank_en,
                    valid:    cfg_valid};
            end
            if (bank_we) begin
                bank_q      <= bank_din;
                bank_mask_q <= bank_mask;
            end
        end
    end

    // Everything a request needs is captured at decode, so later table
    // or bank writes cannot disturb a request already in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sel      <= '0;
            miss     <= 1'b0;
            out_addr <= '0;
            ready    <= 1'b0;
            cnt      <= '0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mreq) begin
                        sel      <= hit_sel;
                        miss     <= ~hit;
                        out_addr <= xlat_addr;
                        cnt      <= win_wait;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mreq) begin
                        sel   <= '0;
                        miss  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - WAIT_MAX'(1);
                    end
                end
                DONE: begin
                    if (!mreq) begin
                        sel   <= '0;
                        miss  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_region_decoder.sv
// Randomised bench for bus_region_decoder with a behavioural table model
// and a per-cycle compare of sel, miss, out_addr and ready.
module tb_bus_region_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [19:0] cfg_base;
    logic [19:0] cfg_mask;
    logic [1:0]  cfg_wait;
    logic        cfg_bank_en;
    logic        cfg_valid;
    logic        bank_we;
    logic [3:0]  bank_din;
    logic [3:0]  bank_mask;
    logic        mreq;
    logic [19:0] A;
    logic [7:0]  sel;
    logic        miss;
    logic [19:0] out_addr;
    logic        ready;

    always #5 clk = ~clk;

    bus_region_decoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_base    (cfg_base),
        .cfg_mask    (cfg_mask),
        .cfg_wait    (cfg_wait),
        .cfg_bank_en (cfg_bank_en),
        .cfg_valid   (cfg_valid),
        .bank_we     (bank_we),
        .bank_din    (bank_din),
        .bank_mask   (bank_mask),
        .mreq        (mreq),
        .A           (A),
        .sel         (sel),
        .miss        (miss),
        .out_addr    (out_addr),
        .ready       (ready)
    );

    // Behavioural model state
    logic [19:0] m_base [8];
    logic [19:0] m_mask [8];
    int          m_wait [8];
    bit          m_ben  [8];
    bit          m_val  [8];
    logic [3:0]  m_bank;
    logic [3:0]  m_bmask;

    logic [7:0]  exp_sel;
    logic        exp_miss;
    logic [19:0] exp_out;
    logic        exp_ready;
    bit          chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sel", {24'd0, sel}, {24'd0, exp_sel});
            chk("miss", {31'd0, miss}, {31'd0, exp_miss});
            chk("out_addr", {12'd0, out_addr}, {12'd0, exp_out});
            chk("ready", {31'd0, ready}, {31'd0, exp_ready});
            chk("sel_onehot", {31'd0, ($countones(sel) <= 1)}, 32'd1);
        end
    end

    function automatic void model_decode(input logic [19:0] a,
        output logic [7:0] es, output logic em,
        output logic [19:0] eo, output int ew);
        int w;
        w  = -1;
        for (int i = 0; i < 8; i++) begin
            if (w < 0 && m_val[i] && ((a & m_mask[i]) == (m_base[i] & m_mask[i])))
                w = i;
        end
        eo = a;
        if (w < 0) begin
            es = 8'd0; em = 1'b1; ew = 0;
        end else begin
            es = 8'd1 << w; em = 1'b0; ew = m_wait[w];
            if (m_ben[w])
                eo[19:16] = (m_bank & m_bmask) | (a[19:16] & ~m_bmask);
        end
    endfunction

    function automatic logic [19:0] rnd_mask();
        case ($urandom_range(0, 4))
            0: return 20'hF0000;
            1: return 20'hFF000;
            2: return 20'hE0000;
            3: return 20'h00000;
            default: return 20'hFFFF0;
        endcase
    endfunction

    task automatic cfg_write(input int idx, input logic [19:0] b,
        input logic [19:0] m, input int w, input bit ben, input bit v);
        cfg_we = 1'b1; cfg_idx = idx[2:0]; cfg_base = b; cfg_mask = m;
        cfg_wait = w[1:0]; cfg_bank_en = ben; cfg_valid = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_base[idx] = b; m_mask[idx] = m; m_wait[idx] = w;
        m_ben[idx] = ben; m_val[idx] = v;
    endtask

    task automatic bank_write(input logic [3:0] b, input logic [3:0] m);
        bank_we = 1'b1; bank_din = b; bank_mask = m;
        @(posedge clk); #1;
        bank_we = 1'b0;
        m_bank = b; m_bmask = m;
    endtask

    // Called just after a rising edge with the decoder idle.
    task automatic run_req(input logic [19:0] addr, input int abort_in,
        input bit mid, input int mid_idx, output int lat);
        logic [7:0]  es;
        logic        em;
        logic [19:0] eo;
        int ew, e, nidx, abort_j;
        bit fin;
        model_decode(addr, es, em, eo, ew);
        lat = -1;
        abort_j = (abort_in > ew) ? ew : abort_in;
        A = addr; mreq = 1'b1;
        @(posedge clk); #1;
        exp_sel = es; exp_miss = em; exp_out = eo;
        nidx = (mid_idx < 0) ? int'($urandom_range(0, 7)) : mid_idx;
        if (mid) begin
            cfg_we = 1'b1; cfg_idx = nidx[2:0];
            cfg_base = 20'($urandom); cfg_mask = rnd_mask();
            cfg_wait = 2'($urandom); cfg_bank_en = 1'($urandom);
            cfg_valid = 1'b1;
            bank_we = 1'b1; bank_din = 4'($urandom); bank_mask = 4'($urandom);
        end
        if (abort_j == 0) mreq = 1'b0;
        e = 0; fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            e++;
            if (ready && lat < 0) lat = e + 1;
            if (e == 1 && mid) begin
                cfg_we = 1'b0; bank_we = 1'b0;
                m_base[nidx] = cfg_base; m_mask[nidx] = cfg_mask;
                m_wait[nidx] = int'(cfg_wait); m_ben[nidx] = cfg_bank_en;
                m_val[nidx] = cfg_valid;
                m_bank = bank_din; m_bmask = bank_mask;
            end
            if (abort_j >= 0) begin
                if (e == abort_j + 1) begin
                    exp_sel = 8'd0; exp_miss = 1'b0; fin = 1'b1;
                end else if (e == abort_j) begin
                    mreq = 1'b0;
                end
            end else begin
                if (e == ew + 1) begin
                    exp_ready = 1'b1; mreq = 1'b0;
                end else if (e == ew + 2) begin
                    exp_ready = 1'b0; exp_sel = 8'd0; exp_miss = 1'b0;
                    fin = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_base[i] = '0; m_mask[i] = '0; m_wait[i] = 0;
            m_ben[i] = 1'b0; m_val[i] = 1'b0;
        end
        m_bank = '0; m_bmask = '0;
        exp_sel = '0; exp_miss = 1'b0; exp_out = '0; exp_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  es;
        logic        em;
        logic [19:0] eo;
        logic [19:0] addr;
        int ew, lat, k, r;

        reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0;
        cfg_mask = '0; cfg_wait = '0; cfg_bank_en = 1'b0; cfg_valid = 1'b0;
        bank_we = 1'b0; bank_din = '0; bank_mask = '0; mreq = 1'b0; A = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_sel", {24'd0, sel}, 32'd0);
        chk("rst_miss", {31'd0, miss}, 32'd0);
        chk("rst_out", {12'd0, out_addr}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk_en = 1'b1;

        // Stock M107 table
        cfg_write(0, 20'hC0000, 20'hF0000, 1, 1'b0, 1'b1);
        cfg_write(1, 20'hD0000, 20'hF0000, 2, 1'b0, 1'b1);
        cfg_write(2, 20'hE0000, 20'hF0000, 0, 1'b0, 1'b1);
        cfg_write(3, 20'hFFFF0, 20'hFFFF0, 1, 1'b0, 1'b1);
        cfg_write(4, 20'hF8000, 20'hF8000, 1, 1'b0, 1'b1);
        cfg_write(5, 20'hF0000, 20'hF8000, 3, 1'b0, 1'b1);
        cfg_write(6, 20'hA0000, 20'hE0000, 1, 1'b1, 1'b1);

        model_decode(20'hC1234, es, em, eo, ew);
        chk("pin_rom_sel", {24'd0, es}, 32'h01);
        chk("pin_rom_out", {12'd0, eo}, 32'hC1234);
        chk("pin_rom_wait", ew, 32'd1);
        run_req(20'hC1234, -1, 1'b0, -1, lat);
        chk("rom_latency", lat, 32'd3);

        bank_write(4'h7, 4'b0001);
        model_decode(20'hA5678, es, em, eo, ew);
        chk("pin_bank_on", {12'd0, eo}, 32'hB5678);
        run_req(20'hA5678, -1, 1'b0, -1, lat);
        cfg_write(6, 20'hA0000, 20'hE0000, 1, 1'b0, 1'b1);
        model_decode(20'hA5678, es, em, eo, ew);
        chk("pin_bank_off", {12'd0, eo}, 32'hA5678);
        run_req(20'hA5678, -1, 1'b0, -1, lat);

        cfg_write(1, 20'hF0000, 20'hF0000, 1, 1'b0, 1'b1);
        cfg_write(0, 20'hFFFF0, 20'hFFFF0, 0, 1'b0, 1'b1);
        model_decode(20'hFFFF4, es, em, eo, ew);
        chk("pin_overlap_sel", {24'd0, es}, 32'h01);
        run_req(20'hFFFF4, -1, 1'b0, -1, lat);

        for (int i = 0; i < 8; i++) cfg_write(i, 20'h0, 20'h0, 0, 1'b0, 1'b0);
        model_decode(20'h12345, es, em, eo, ew);
        chk("pin_miss_flag", {31'd0, em}, 32'd1);
        run_req(20'h12345, -1, 1'b0, -1, lat);
        chk("miss_latency", lat, 32'd2);

        cfg_write(0, 20'h0, 20'h0, 3, 1'b0, 1'b1);
        run_req(20'h12345, 1, 1'b0, -1, lat);
        chk("abort_no_ready", lat, 32'hFFFFFFFF);

        cfg_write(0, 20'h0, 20'h0, 2, 1'b0, 1'b1);
        run_req(20'h54321, -1, 1'b1, 0, lat);
        run_req(20'h54321, -1, 1'b0, -1, lat);

        // Asynchronous reset in the middle of a wait
        cfg_write(0, 20'h0, 20'h0, 3, 1'b0, 1'b1);
        A = 20'h12345; mreq = 1'b1;
        @(posedge clk); #1;
        exp_sel = 8'h01; exp_miss = 1'b0; exp_out = 20'h12345;
        @(posedge clk); #2;
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_sel", {24'd0, sel}, 32'd0);
        chk("async_miss", {31'd0, miss}, 32'd0);
        chk("async_out", {12'd0, out_addr}, 32'd0);
        chk("async_ready", {31'd0, ready}, 32'd0);
        mreq = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en = 1'b1;
        run_req(20'hC1234, -1, 1'b0, -1, lat);
        chk("post_reset_latency", lat, 32'd2);

        for (int i = 0; i < 8; i++)
            cfg_write(i, 20'($urandom), rnd_mask(), int'($urandom_range(0, 3)),
                      1'($urandom), ($urandom_range(0, 3) != 0));
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                cfg_write(int'($urandom_range(0, 7)), 20'($urandom), rnd_mask(),
                          int'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 3) != 0));
            end else if (r == 1) begin
                bank_write(4'($urandom), 4'($urandom));
            end else begin
                k = int'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1)
                    addr = (m_base[k] & m_mask[k]) | (20'($urandom) & ~m_mask[k]);
                else
                    addr = 20'($urandom);
                run_req(addr,
                        ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
                        ($urandom_range(0, 5) == 0), -1, lat);
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
